// File: rtl/multi_channel_capture.sv
// multi_channel_capture: NCH-channel trigger-and-capture buffer.
// While armed, every channel is written into its own circular buffer at a
// shared write pointer. A qualified trigger freezes a pre/post-trigger window,
// which is then streamed out channel by channel over rd_req/rd_valid.
// Optional feature macro: SELF_TRIGGER_EN. When it is defined, any channel
// sample >= threshold (unsigned) acts as an extra trigger source.

// Per-channel storage: one circular buffer plus a registered read port.
module capture_lane #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    input  logic [WIDTH-1:0]      threshold,
    output logic [WIDTH-1:0]      rd_q,
    output logic                  hit
);
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Sample write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Registered read: data appears the cycle after the read is issued.
    always_ff @(posedge clk) begin
        if (!reset_n)  rd_q <= '0;
        else if (re)   rd_q <= mem[rd_addr];
    end

    assign hit = (wr_data >= threshold);
endmodule

module multi_channel_capture #(
    parameter int NCH        = 4,
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic [NCH*WIDTH-1:0]  sample_data,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic [WIDTH-1:0]      threshold,
    input  logic [DEPTH_LOG2-1:0] pre_samples,
    input  logic [DEPTH_LOG2-1:0] post_samples,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_data,
    output logic [7:0]            rd_ch,
    output logic                  rd_last,
    output logic                  ro_done,
    output logic                  busy,
    output logic [1:0]            state_out,
    output logic [7:0]            trig_reject
);
    localparam int D = DEPTH_LOG2;
    // Largest pre-trigger count and largest total window (one slot stays free
    // so the post-trigger writes never overrun the oldest pre-trigger word).
    localparam logic [D:0] P_MAX   = (D+1)'(2**D - 2);
    localparam logic [D:0] L_MAX   = (D+1)'(2**D - 1);
    localparam logic [7:0] LAST_CH = 8'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_POST    = 2'b10,
        S_READOUT = 2'b11
    } state_t;

    typedef struct packed {
        logic [D:0] p;   // pre-trigger words
        logic [D:0] q;   // post-trigger words (including trigger sample)
    } window_t;

    state_t  state, state_nxt;
    window_t win, win_calc;

    logic [D-1:0] wr_ptr, trig_ptr, fill, post_cnt, rd_idx;
    logic [D-1:0] l_win, start_ptr, rd_addr;
    logic [D:0]   l_sum, p_c, q_c;
    logic [7:0]   rd_chan;
    logic         issue_done;
    logic         wr_en, trig_ev, trig_qual, post_done, rd_issue, last_word;

    logic [NCH-1:0][WIDTH-1:0] samples, lane_q;
    logic [NCH-1:0]            lane_hit;

    assign samples = sample_data;

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_lane
            capture_lane #(.WIDTH(WIDTH), .DEPTH_LOG2(D)) u_lane (
                .clk       (clk),
                .reset_n   (reset_n),
                .we        (wr_en),
                .wr_addr   (wr_ptr),
                .wr_data   (samples[k]),
                .re        (rd_issue),
                .rd_addr   (rd_addr),
                .threshold (threshold),
                .rd_q      (lane_q[k]),
                .hit       (lane_hit[k])
            );
        end
    endgenerate

`ifdef SELF_TRIGGER_EN
    assign trig_ev = trigger | (sample_valid & (|lane_hit));
`else
    logic unused_hit;
    assign unused_hit = ^lane_hit;
    assign trig_ev    = trigger;
`endif

    // Window sizing from the runtime inputs: clamp P, force Q >= 1, shrink Q
    // so the whole window fits in the buffer.
    always_comb begin
        p_c = ({1'b0, pre_samples} > P_MAX) ? P_MAX : {1'b0, pre_samples};
        q_c = (post_samples == '0) ? (D+1)'(1) : {1'b0, post_samples};
        if (p_c + q_c > L_MAX) q_c = L_MAX - p_c;
        win_calc.p = p_c;
        win_calc.q = q_c;
    end

    assign l_sum     = win.p + win.q;
    assign l_win     = l_sum[D-1:0];
    assign start_ptr = trig_ptr - win.p[D-1:0];
    assign rd_addr   = start_ptr + rd_idx;

    assign wr_en     = sample_valid && (state == S_ARMED || state == S_POST);
    assign trig_qual = trig_ev && ({1'b0, fill} >= win.p);
    assign post_done = sample_valid && (({1'b0, post_cnt} + (D+1)'(1)) == win.q);
    assign rd_issue  = (state == S_READOUT) && rd_req && !issue_done;
    assign last_word = (rd_chan == LAST_CH) && (rd_idx == l_win - D'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; READOUT exits the cycle after the final word is shown.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (arm) state_nxt = S_ARMED;
            S_ARMED:   if (trig_qual)
                           state_nxt = (sample_valid && win.q == (D+1)'(1)) ? S_READOUT : S_POST;
            S_POST:    if (post_done) state_nxt = S_READOUT;
            S_READOUT: if (rd_valid && rd_last) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Capture side: write pointer, fill level, window latch, trigger handling.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            fill        <= '0;
            win         <= '0;
            trig_ptr    <= '0;
            post_cnt    <= '0;
            trig_reject <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill != '1) fill <= fill + 1'b1;
            end
            if (state == S_IDLE && arm) begin
                win  <= win_calc;
                fill <= '0;
            end
            if (state == S_ARMED && trig_ev) begin
                if (trig_qual) begin
                    // The sample written this cycle is the first post sample.
                    trig_ptr <= wr_ptr;
                    post_cnt <= sample_valid ? D'(1) : '0;
                end else if (trig_reject != 8'hFF) begin
                    trig_reject <= trig_reject + 8'd1;
                end
            end
            if (state == S_POST && sample_valid) post_cnt <= post_cnt + 1'b1;
        end
    end

    // Readout sequencing: word index within a channel, then channel index.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_idx     <= '0;
            rd_chan    <= '0;
            issue_done <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            rd_ch      <= '0;
        end else begin
            rd_valid <= rd_issue;
            rd_last  <= rd_issue && last_word;
            if (rd_issue) begin
                rd_ch <= rd_chan;
                if (rd_idx == l_win - D'(1)) begin
                    rd_idx <= '0;
                    if (rd_chan == LAST_CH) issue_done <= 1'b1;
                    else                    rd_chan    <= rd_chan + 8'd1;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
            if (state != S_READOUT) begin
                rd_idx     <= '0;
                rd_chan    <= '0;
                issue_done <= 1'b0;
            end
        end
    end

    // Output word select by the channel of the word just read.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCH; i++)
            if (rd_ch == 8'(i)) rd_data = lane_q[i];
    end

    assign ro_done   = rd_valid & rd_last;
    assign busy      = (state != S_IDLE);
    assign state_out = state;
endmodule

// File: tb/tb_multi_channel_capture.sv
// Directed bench for multi_channel_capture (NCH=4, WIDTH=12, DEPTH_LOG2=4).
// Channel k sample n carries the value 0x100*k + n.
module tb_multi_channel_capture;
    localparam int NCH = 4;
    localparam int W   = 12;
    localparam int D   = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           sample_valid;
    logic [NCH*W-1:0] sample_data;
    logic           arm, trigger, rd_req;
    logic [W-1:0]   threshold;
    logic [D-1:0]   pre_samples, post_samples;
    logic           rd_valid, rd_last, ro_done, busy;
    logic [W-1:0]   rd_data;
    logic [7:0]     rd_ch, trig_reject;
    logic [1:0]     state_out;

    int n_vec  = 0;
    int n_miss = 0;

    multi_channel_capture #(.NCH(NCH), .WIDTH(W), .DEPTH_LOG2(D)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .arm          (arm),
        .trigger      (trigger),
        .threshold    (threshold),
        .pre_samples  (pre_samples),
        .post_samples (post_samples),
        .rd_req       (rd_req),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ch        (rd_ch),
        .rd_last      (rd_last),
        .ro_done      (ro_done),
        .busy         (busy),
        .state_out    (state_out),
        .trig_reject  (trig_reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCH*W-1:0] mk(input int n);
        logic [NCH*W-1:0] v;
        v = '0;
        for (int k = 0; k < NCH; k++) v[k*W +: W] = W'(256*k + n);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input bit trg);
        sample_data  = mk(n);
        sample_valid = 1'b1;
        trigger      = trg;
        tick();
        sample_valid = 1'b0;
        trigger      = 1'b0;
    endtask

    task automatic push_range(input int a, input int b);
        for (int n = a; n <= b; n++) push(n, 1'b0);
    endtask

    task automatic arm_win(input int pre, input int post);
        pre_samples  = D'(pre);
        post_samples = D'(post);
        arm          = 1'b1;
        tick();
        arm          = 1'b0;
    endtask

    // Drain the window; mode 0 = rd_req held high, mode 1 = 1,0,0 pattern.
    task automatic read_window(input int n0, input int l, input int mode);
        int total, issued, got, cyc;
        bit req_was;
        total  = NCH * l;
        issued = 0;
        got    = 0;
        cyc    = 0;
        while (got < total && cyc < 400) begin
            rd_req = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            req_was = rd_req;
            tick();
            chk("rd_valid", {31'b0, rd_valid}, {31'b0, req_was && issued < total});
            if (req_was && issued < total) issued++;
            if (rd_valid) begin
                chk("rd_data", {20'b0, rd_data}, 32'(256*(got / l) + n0 + (got % l)));
                chk("rd_ch",   {24'b0, rd_ch},   32'(got / l));
                chk("rd_last", {31'b0, rd_last}, {31'b0, got == total-1});
                chk("ro_done", {31'b0, ro_done}, {31'b0, got == total-1});
                got++;
            end
            cyc++;
        end
        if (got < total) chk("rd_timeout", 32'(got), 32'(total));
        // rd_req still as last driven: nothing further may be issued.
        rd_req = 1'b1;
        tick();
        chk("post_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("post_rd_state", {30'b0, state_out}, 32'd0);
        rd_req = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        arm          = 1'b0;
        trigger      = 1'b0;
        rd_req       = 1'b0;
        threshold    = 12'h800;
        pre_samples  = '0;
        post_samples = '0;
        tick();
        tick();
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_rd_data",  {20'b0, rd_data},  32'd0);
        chk("rst_rd_ch",    {24'b0, rd_ch},    32'd0);
        chk("rst_rd_last",  {31'b0, rd_last},  32'd0);
        chk("rst_ro_done",  {31'b0, ro_done},  32'd0);
        chk("rst_busy",     {31'b0, busy},     32'd0);
        chk("rst_state",    {30'b0, state_out}, 32'd0);
        chk("rst_reject",   {24'b0, trig_reject}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic capture, pre=4 post=4, trigger with sample 10.
        arm_win(4, 4);
        chk("t1_armed", {30'b0, state_out}, 32'd1);
        chk("t1_busy",  {31'b0, busy}, 32'd1);
        push_range(0, 9);
        chk("t1_still_armed", {30'b0, state_out}, 32'd1);
        push(10, 1'b1);
        chk("t1_post", {30'b0, state_out}, 32'd2);
        push_range(11, 12);
        chk("t1_post2", {30'b0, state_out}, 32'd2);
        push(13, 1'b0);
        chk("t1_readout", {30'b0, state_out}, 32'd3);
        read_window(6, 8, 0);

        // Same capture, stalled readout.
        arm_win(4, 4);
        push_range(0, 9);
        push(10, 1'b1);
        push_range(11, 13);
        chk("t4_readout", {30'b0, state_out}, 32'd3);
        read_window(6, 8, 1);

        // Trigger in IDLE is ignored and not counted.
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("idle_trig_state",  {30'b0, state_out},   32'd0);
        chk("idle_trig_reject", {24'b0, trig_reject}, 32'd0);

        // Early trigger rejected, later one accepted; re-arm while ARMED ignored.
        arm_win(4, 4);
        push_range(0, 1);
        push(2, 1'b1);
        chk("t2_state",  {30'b0, state_out},   32'd1);
        chk("t2_reject", {24'b0, trig_reject}, 32'd1);
        arm_win(0, 1);
        chk("t2_rearm", {30'b0, state_out}, 32'd1);
        push_range(3, 5);
        push(6, 1'b1);
        chk("t2_post", {30'b0, state_out}, 32'd2);
        push_range(7, 9);
        chk("t2_readout", {30'b0, state_out}, 32'd3);
        read_window(2, 8, 0);

        // Wrap and clamp: pre=8 post=8 -> Q=7, 15 words per channel.
        arm_win(8, 8);
        push_range(0, 39);
        push(40, 1'b1);
        push_range(41, 45);
        chk("t3_post", {30'b0, state_out}, 32'd2);
        push(46, 1'b0);
        chk("t3_readout", {30'b0, state_out}, 32'd3);
        read_window(32, 15, 0);

        // Reset during POST.
        arm_win(4, 4);
        push_range(0, 5);
        push(6, 1'b1);
        chk("t5_post", {30'b0, state_out}, 32'd2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t5_state",  {30'b0, state_out},   32'd0);
        chk("t5_busy",   {31'b0, busy},        32'd0);
        chk("t5_reject", {24'b0, trig_reject}, 32'd0);
        chk("t5_valid",  {31'b0, rd_valid},    32'd0);
        push(7, 1'b1);
        chk("t5_trig_ignored", {30'b0, state_out},   32'd0);
        chk("t5_reject2",      {24'b0, trig_reject}, 32'd0);

        // Self-trigger: ch2 reaches threshold after the pre window has filled.
        arm_win(4, 4);
        push_range(0, 4);
        sample_data = mk(5);
        sample_data[2*W +: W] = 12'h800;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
`ifdef SELF_TRIGGER_EN
        chk("t6_self_trig", {30'b0, state_out}, 32'd2);
`else
        chk("t6_no_self_trig", {30'b0, state_out}, 32'd1);
`endif
        chk("t6_reject", {24'b0, trig_reject}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/multi_channel_capture.md
# multi_channel_capture

Parametrised NCH-channel trigger-and-capture block: continuously records parallel ADC samples into per-channel circular buffers while armed, freezes a pre/post-trigger window on a trigger, then streams the window out channel by channel over a valid/request handshake. Sits downstream of the LVDS deserialisers and upstream of the SPI/readout logic. Generalises the single-channel buffer/state-machine/address-control chain to N channels, runtime window sizing, trigger qualification and stall-able readout.

## Interface
- NCH, 4, number of channels sharing one write pointer
- WIDTH, 12, sample width in bits
- DEPTH_LOG2, 10, buffer depth per channel = 2^DEPTH_LOG2 words
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- sample_valid  in  1  one sample per channel present this cycle
- sample_data  in  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- arm  in  1  start acquisition (honoured in IDLE only)
- trigger  in  1  external trigger (honoured in ARMED only)
- threshold  in  WIDTH  self-trigger level (used only with SELF_TRIGGER_EN)
- pre_samples  in  DEPTH_LOG2  samples kept before trigger
- post_samples  in  DEPTH_LOG2  samples kept from trigger on
- rd_req  in  1  readout request/advance
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  WIDTH  readout word
- rd_ch  out  8  channel index of rd_data
- rd_last  out  1  final word of final channel
- ro_done  out  1  one-cycle pulse, readout complete
- busy  out  1  state != IDLE
- state_out  out  2  IDLE=00, ARMED=01, POST=10, READOUT=11
- trig_reject  out  8  saturating count of disqualified triggers

## Operation
- Window latched on arm: P = min(pre_samples, 2^D-2); Q = max(post_samples,1), clamped so P+Q <= 2^D-1 (Q reduced); arithmetic in DEPTH_LOG2+1 bits. L = P+Q.
- IDLE: no writes. arm -> ARMED; fill counter cleared; wr_ptr retained.
- ARMED: each sample_valid writes all NCH channels at wr_ptr, wr_ptr = wr_ptr+1 mod 2^D; fill saturates at 2^D-1.
- Trigger qualified when fill >= P. Qualified -> POST, trig_ptr = wr_ptr (sample written in the trigger cycle is first post sample). Unqualified -> stay ARMED, trig_reject++ (saturate 255).
- POST: writes continue; post counter counts writes; after Q-th write -> READOUT. start = trig_ptr - P mod 2^D.
- READOUT: writes blocked. Order ch0 words start..start+L-1 (wrapping), then ch1, … ch NCH-1. Each cycle with rd_req=1 issues one read; rd_req=0 pauses with no loss. After last issued word, further rd_req ignored.
- arm outside IDLE, trigger outside ARMED: ignored (no reject count).
- Reset mid-operation: state IDLE, wr_ptr/fill/counters 0, all outputs 0; buffer contents not cleared.

## Timing
- Reset values: rd_valid 0, rd_data 0, rd_ch 0, rd_last 0, ro_done 0, busy 0, state_out 00, trig_reject 0.
- arm/trigger sampled at edge; state_out changes next cycle.
- Read latency 1: rd_req high in cycle n -> rd_valid, rd_data, rd_ch in n+1.
- rd_last and ro_done assert with final rd_valid; state_out 00 the following cycle.
- Total readout = NCH*L words; minimum NCH*L+1 cycles from first rd_req.
- Capture in same cycle as POST->READOUT: final sample written, state changes after.

## Configuration
- SELF_TRIGGER_EN defined: in ARMED, any channel with sample_valid and sample >= threshold (unsigned) acts as trigger, OR'd with trigger, same qualification/reject rules.
- Undefined: threshold ignored; only external trigger.

## Test plan
- NCH=4, WIDTH=12, D=4, ch k sample n = 0x100*k+n; pre=4, post=4, trigger with sample 10 -> 32 words: ch0 0x006..0x00D, ch1 0x106..0x10D, …; rd_last+ro_done on 32nd.
- pre=4, trigger after 2 samples -> stays ARMED, trig_reject=1; trigger at sample 6 -> window 0x002..0x009.
- Wrap/clamp: 40 samples, pre=8, post=8, trigger at sample 40 -> Q clamped 7, ch0 = 0x020..0x02E (15 words).
- rd_req toggling 1,0,0,1,… -> rd_valid only cycle after each request; sequence identical to test 1, no gaps lost or duplicated.
- reset_n low one cycle during POST -> state_out 00, busy 0, trig_reject 0; trigger ignored until arm.
- SELF_TRIGGER_EN, threshold 0x800, ch2 sample 0x800 after fill -> POST; without macro same stimulus stays ARMED.
